button_pulse_conditioner: RTL

Front-end conditioning stage feeding the password checker. It synchronises and debounces the raw load and logout push-buttons and the 4-bit switch bank. It emits single-cycle Load_Button_PSWD_Game_Control and Logout_Pulse strobes, plus a Data_in word that is held stable and captured on the load strobe. This replaces the raw button drive the checker currently receives.

---
 rtl/button_pulse_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner
// Front-end for the password checker. It synchronises and debounces the raw
// load and logout push-buttons and the switch bank. It produces one-cycle
// load/logout strobes and a Data_in word that is captured on the load strobe.
// Optional build macro: LONG_PRESS_LOGOUT_EN. When it is defined, logout
// fires only after the button has been held for LONG_CNT debounced cycles.

module button_pulse_conditioner #(
  parameter int DEBOUNCE_CNT = 4,
  parameter int LONG_CNT     = 16,
  parameter int DATA_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Btn_Load_Raw,
  input  logic              Btn_Logout_Raw,
  input  logic [DATA_W-1:0] Sw_Raw,
  output logic              Load_Button_PSWD_Game_Control,
  output logic              Logout_Pulse,
  output logic [DATA_W-1:0] Data_in
);

  localparam int              CntW     = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CNT - 1);
  localparam int              LoadCh   = 0;
  localparam int              LogoutCh = 1;

  // Reject illegal parameter values while the design is being elaborated.
  if (DEBOUNCE_CNT < 1 || LONG_CNT < 1 || DATA_W < 1) begin : gBadParams
    $error("button_pulse_conditioner: DEBOUNCE_CNT, LONG_CNT and DATA_W must be >= 1");
  end

  logic [1:0]        btnSync1;
  logic [1:0]        btnSync2;
  logic [DATA_W-1:0] swSync1;
  logic [DATA_W-1:0] swSync2;
  logic [1:0]        btnDb;
  logic [CntW-1:0]   btnCnt [2];
  logic [1:0]        dbRise;
  logic              loadFire;
  logic              logoutFire;

  // Two-flop synchronisers. Each raw input gets its own flop pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btnSync1 <= '0;
      btnSync2 <= '0;
      swSync1  <= '0;
      swSync2  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample its pre-edge
      // value, so the two stages really form a two-cycle pipeline.
      btnSync1 <= {Btn_Logout_Raw, Btn_Load_Raw};
      btnSync2 <= btnSync1;
      swSync1  <= Sw_Raw;
      swSync2  <= swSync1;
    end
  end

  // Per-button debounce. A change is accepted only after the synchronised
  // level has differed from db for DEBOUNCE_CNT consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btnDb <= '0;
      // NOTE: the counter array is just two small registers, not a RAM, so
      // clearing it in reset is cheap and discards any partial count.
      for (int ch = 0; ch < 2; ch++) btnCnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (btnSync2[ch] == btnDb[ch]) begin
          btnCnt[ch] <= '0;
        end else if (btnCnt[ch] == CntLast) begin
          btnDb[ch]  <= btnSync2[ch];
          btnCnt[ch] <= '0;
        end else begin
          btnCnt[ch] <= btnCnt[ch] + 1'b1;
        end
      end
    end
  end

  // Flag the edge on which a debounced state is about to go 0->1.
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational;
    // a path that left dbRise unassigned would infer a latch.
    dbRise = '0;
    for (int ch = 0; ch < 2; ch++) begin
      dbRise[ch] = btnSync2[ch] & ~btnDb[ch] & (btnCnt[ch] == CntLast);
    end
  end

`ifdef LONG_PRESS_LOGOUT_EN
  localparam int               HoldW    = $clog2(LONG_CNT) + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CNT - 1);

  logic [HoldW-1:0] holdCnt;
  logic             holdDone;

  // Count cycles while the debounced logout stays high. The pulse fires
  // once, when the count reaches LONG_CNT.
  always_ff @(posedge clk) begin
    if (!rst || !btnDb[LogoutCh]) begin
      holdCnt  <= '0;
      holdDone <= 1'b0;
    end else if (!holdDone) begin
      if (holdCnt == HoldLast) holdDone <= 1'b1;
      holdCnt <= holdCnt + 1'b1;
    end
  end

  assign logoutFire = btnDb[LogoutCh] & ~holdDone & (holdCnt == HoldLast);
`else
  assign logoutFire = dbRise[LogoutCh];
`endif

  // Logout wins when both strobes would fire on the same edge.
  assign loadFire = dbRise[LoadCh] & ~logoutFire;

  // Register the strobes. The switch word is captured only with a load strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      Load_Button_PSWD_Game_Control <= 1'b0;
      Logout_Pulse                  <= 1'b0;
      Data_in                       <= '0;
    end else begin
      Load_Button_PSWD_Game_Control <= loadFire;
      Logout_Pulse                  <= logoutFire;
      if (loadFire) Data_in <= swSync2;
    end
  end

endmodule
